// File: rtl/uart_cmd_sequencer_pkg.sv
// Shared types and constants for the UART register-write command sequencer.
package uart_cmd_pkg;

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned WDATA_W = 16;
   localparam int unsigned TIMER_W = 20;
   localparam int unsigned PKT_LEN = 5;

   localparam logic [BYTE_W-1:0] ST_OK      = 8'h55;
   localparam logic [BYTE_W-1:0] ST_BADCHK  = 8'hEE;
   localparam logic [BYTE_W-1:0] ST_BYTE_TO = 8'hE0;
   localparam logic [BYTE_W-1:0] ST_ACK_TO  = 8'hEF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_ADDR,
      S_GET_DH,
      S_GET_DL,
      S_GET_CHK,
      S_ISSUE,
      S_WAIT_ACK,
      S_RESPOND
   } state_t;

   typedef struct packed {
      logic [BYTE_W-1:0]  addr;
      logic [WDATA_W-1:0] wdata;
   } reg_wr_t;

   // Expected CHK byte for an assembled packet.
   function automatic logic [BYTE_W-1:0] pkt_chk(input reg_wr_t p);
      return p.addr ^ p.wdata[WDATA_W-1:BYTE_W] ^ p.wdata[BYTE_W-1:0];
   endfunction

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// Byte-receive, register-write, status-transmit and status signals of the sequencer.
interface uart_cmd_sequencer_if;
   import uart_cmd_pkg::*;

   logic [BYTE_W-1:0]  rx_data;
   logic               rx_ready;
   logic               reg_req;
   logic [BYTE_W-1:0]  reg_addr;
   logic [WDATA_W-1:0] reg_wdata;
   logic               reg_ack;
   logic [BYTE_W-1:0]  tx_data;
   logic               tx_start;
   logic               tx_busy;
   logic               busy;
   logic [BYTE_W-1:0]  drop_cnt;

   modport master (
      input  rx_data, rx_ready, reg_ack, tx_busy,
      output reg_req, reg_addr, reg_wdata, tx_data, tx_start, busy, drop_cnt
   );

   modport slave (
      output rx_data, rx_ready, reg_ack, tx_busy,
      input  reg_req, reg_addr, reg_wdata, tx_data, tx_start, busy, drop_cnt
   );

endinterface

// File: rtl/uart_cmd_sequencer_cmd_timer.sv
// Clearable up-counter with a compare-to-limit flag, shared by byte and ACK timeouts.
module cmd_timer
   import uart_cmd_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               en,
   input  logic [TIMER_W-1:0] limit,
   output logic               expired_c
);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + TIMER_W'(1);
      end
   end

   assign expired_c = en && (count == limit);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Assembles SYNC/ADDR/DH/DL/CHK packets, issues register writes and replies with a status byte.
module uart_cmd_sequencer
   import uart_cmd_pkg::*;
#(
   parameter logic [BYTE_W-1:0] SYNC_BYTE    = 8'hAA,
   parameter int unsigned       BYTE_TIMEOUT = 27000,
   parameter int unsigned       ACK_TIMEOUT  = 270000
) (
   input logic                  clk,
   input logic                  rst_n,
   uart_cmd_sequencer_if.master bus
);

   state_t             state;
   reg_wr_t            shadow;
   logic [BYTE_W-1:0]  status;
   logic [BYTE_W-1:0]  drop_cnt;
   logic [BYTE_W-1:0]  tx_data;
   logic [BYTE_W-1:0]  reg_addr;
   logic [WDATA_W-1:0] reg_wdata;
   logic               reg_req;
   logic               tx_start;
   logic               busy;

   logic               get_c;
   logic               tmr_en_c;
   logic               tmr_clr_c;
   logic               expired_c;
   logic               drop_c;
   logic [TIMER_W-1:0] limit_c;

   // Timer runs while collecting bytes or waiting for ACK; any accepted byte restarts it.
   assign get_c     = state inside {S_GET_ADDR, S_GET_DH, S_GET_DL, S_GET_CHK};
   assign tmr_en_c  = get_c || (state == S_WAIT_ACK);
   assign tmr_clr_c = !tmr_en_c || (get_c && bus.rx_ready);
   assign limit_c   = (state == S_WAIT_ACK) ? TIMER_W'(ACK_TIMEOUT - 1)
                                            : TIMER_W'(BYTE_TIMEOUT - 1);
   assign drop_c    = bus.rx_ready && (state inside {S_ISSUE, S_WAIT_ACK, S_RESPOND});

   cmd_timer u_cmd_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (tmr_clr_c),
      .en        (tmr_en_c),
      .limit     (limit_c),
      .expired_c (expired_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         shadow    <= '0;
         status    <= '0;
         drop_cnt  <= '0;
         tx_data   <= '0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_req   <= 1'b0;
         tx_start  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         if (drop_c && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + BYTE_W'(1);
         end
         case (state)
            S_IDLE: begin
               if (bus.rx_ready && (bus.rx_data == SYNC_BYTE)) begin
                  state <= S_GET_ADDR;
                  busy  <= 1'b1;
               end
            end
            S_GET_ADDR, S_GET_DH, S_GET_DL: begin
               // A byte arriving on the expiry cycle takes priority over the timeout.
               if (bus.rx_ready) begin
                  if (state == S_GET_ADDR) begin
                     shadow.addr <= bus.rx_data;
                     state       <= S_GET_DH;
                  end else if (state == S_GET_DH) begin
                     shadow.wdata[WDATA_W-1:BYTE_W] <= bus.rx_data;
                     state                          <= S_GET_DL;
                  end else begin
                     shadow.wdata[BYTE_W-1:0] <= bus.rx_data;
                     state                    <= S_GET_CHK;
                  end
               end else if (expired_c) begin
                  status <= ST_BYTE_TO;
                  state  <= S_RESPOND;
               end
            end
            S_GET_CHK: begin
               if (bus.rx_ready) begin
                  if (bus.rx_data == pkt_chk(shadow)) begin
                     state <= S_ISSUE;
                  end else begin
                     status <= ST_BADCHK;
                     state  <= S_RESPOND;
                  end
               end else if (expired_c) begin
                  status <= ST_BYTE_TO;
                  state  <= S_RESPOND;
               end
            end
            S_ISSUE: begin
               reg_addr  <= shadow.addr;
               reg_wdata <= shadow.wdata;
               reg_req   <= 1'b1;
               state     <= S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               if (bus.reg_ack) begin
                  reg_req <= 1'b0;
                  status  <= ST_OK;
                  state   <= S_RESPOND;
               end else if (expired_c) begin
                  reg_req <= 1'b0;
                  status  <= ST_ACK_TO;
                  state   <= S_RESPOND;
               end
            end
            S_RESPOND: begin
               if (!bus.tx_busy) begin
                  tx_start <= 1'b1;
                  tx_data  <= status;
                  state    <= S_IDLE;
                  busy     <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.reg_req   = reg_req;
   assign bus.reg_addr  = reg_addr;
   assign bus.reg_wdata = reg_wdata;
   assign bus.tx_data   = tx_data;
   assign bus.tx_start  = tx_start;
   assign bus.busy      = busy;
   assign bus.drop_cnt  = drop_cnt;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Self-checking bench for uart_cmd_sequencer: vector table, timing corner cases, random packets.
module tb_uart_cmd_sequencer;
   import uart_cmd_pkg::*;

   localparam int unsigned BT     = 40;
   localparam int unsigned AT     = 120;
   localparam int          BUDGET = 2000;
   localparam int          NV     = 7;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_cmd_sequencer_if bus ();

   uart_cmd_sequencer #(
      .SYNC_BYTE    (8'hAA),
      .BYTE_TIMEOUT (BT),
      .ACK_TIMEOUT  (AT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [23:0] req_q[$];
   logic [7:0]  tx_q[$];
   logic        prev_req = 1'b0;
   logic        prev_tx  = 1'b0;
   logic [23:0] held    = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Bus observer: records requests and transmit strobes, checks payload stability and pulse width.
   always @(negedge clk) begin
      if (bus.reg_req && !prev_req) begin
         held = {bus.reg_addr, bus.reg_wdata};
         req_q.push_back(held);
      end else if (bus.reg_req && prev_req) begin
         check("req_payload_stable", {8'h00, bus.reg_addr, bus.reg_wdata}, {8'h00, held});
      end
      if (bus.tx_start) tx_q.push_back(bus.tx_data);
      if (prev_tx) check("tx_start_one_cycle", bus.tx_start, 0);
      prev_req = bus.reg_req;
      prev_tx  = bus.tx_start;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation still running, required finished");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_ready = 1'b1;
      tick();
      bus.rx_ready = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      while (bus.busy && t < BUDGET) begin
         tick();
         t++;
      end
      check({name, " busy_clear"}, bus.busy, 0);
      tick();
   endtask

   // Called right after the CHK strobe: acknowledge a request if one appears, then drain.
   task automatic serve_pkt(input string name, input bit exp_req, input int ack_dly, input int n_extra);
      tick();
      check({name, " req_rise"}, bus.reg_req, exp_req);
      if (bus.reg_req) begin
         for (int i = 0; i < ack_dly; i++) begin
            if (i < n_extra) send_byte(8'($urandom));
            else tick();
            check({name, " req_held"}, bus.reg_req, 1);
         end
         bus.reg_ack = 1'b1;
         tick();
         bus.reg_ack = 1'b0;
         check({name, " req_drop_on_ack"}, bus.reg_req, 0);
      end
      wait_idle(name);
   endtask

   task automatic check_results(input string name, input int nreq, input logic [7:0] addr,
                                input logic [15:0] wdata, input int ntx, input logic [7:0] st);
      check({name, " req_count"}, req_q.size(), nreq);
      if (nreq > 0 && req_q.size() > 0) check({name, " req_payload"}, req_q.pop_front(), {addr, wdata});
      check({name, " tx_count"}, tx_q.size(), ntx);
      if (ntx > 0 && tx_q.size() > 0) check({name, " status"}, tx_q.pop_front(), st);
      req_q.delete();
      tx_q.delete();
   endtask

   task automatic send_pkt(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl,
                           input logic [7:0] chk, input int gap);
      logic [7:0] p [PKT_LEN];
      p[0] = 8'hAA; p[1] = a; p[2] = dh; p[3] = dl; p[4] = chk;
      for (int i = 0; i < PKT_LEN; i++) begin
         if (i > 0) idle(gap);
         send_byte(p[i]);
      end
   endtask

   // Reference: status a well-timed, acknowledged packet must earn.
   function automatic logic [7:0] ref_status(input logic [7:0] a, input logic [7:0] dh,
                                             input logic [7:0] dl, input logic [7:0] chk);
      return ((a ^ dh ^ dl) == chk) ? 8'h55 : 8'hEE;
   endfunction

   typedef struct {
      logic [55:0] b;
      int          n;
      int          gap;
      bit          exp_req;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [7:0]  st;
   } vec_t;

   vec_t       vec [NV];
   logic [7:0] cur;
   int         n;
   int         hi;
   int         seen;
   int         exp_drop;
   bit         found;
   logic [7:0] a, dh, dl, chk, g;
   bit         good;
   int         ad, ne, ng;

   initial begin
      bus.rx_data  = '0;
      bus.rx_ready = 1'b0;
      bus.reg_ack  = 1'b0;
      bus.tx_busy  = 1'b0;

      vec[0] = '{b:56'hAA_10_12_34_36_00_00, n:5, gap:26,   exp_req:1, addr:8'h10, wdata:16'h1234, st:8'h55};
      vec[1] = '{b:56'hAA_10_12_34_00_00_00, n:5, gap:3,    exp_req:0, addr:8'h00, wdata:16'h0000, st:8'hEE};
      vec[2] = '{b:56'h00_FF_AA_01_00_02_03, n:7, gap:3,    exp_req:1, addr:8'h01, wdata:16'h0002, st:8'h55};
      vec[3] = '{b:56'hAA_AA_AA_AA_AA_00_00, n:5, gap:0,    exp_req:1, addr:8'hAA, wdata:16'hAAAA, st:8'h55};
      vec[4] = '{b:56'hAA_10_12_34_36_00_00, n:5, gap:BT-1, exp_req:1, addr:8'h10, wdata:16'h1234, st:8'h55};
      vec[5] = '{b:56'h55_AA_00_00_00_01_00, n:6, gap:1,    exp_req:0, addr:8'h00, wdata:16'h0000, st:8'hEE};
      vec[6] = '{b:56'hAA_FF_00_FF_00_00_00, n:5, gap:2,    exp_req:1, addr:8'hFF, wdata:16'h00FF, st:8'h55};

      // Reset values
      idle(3);
      check("rst reg_req", bus.reg_req, 0);
      check("rst reg_addr", bus.reg_addr, 0);
      check("rst reg_wdata", bus.reg_wdata, 0);
      check("rst tx_data", bus.tx_data, 0);
      check("rst tx_start", bus.tx_start, 0);
      check("rst busy", bus.busy, 0);
      check("rst drop_cnt", bus.drop_cnt, 0);
      rst_n = 1'b1;
      idle(2);

      // Vector table; entry 4 delivers every byte on the exact expiry cycle
      for (int v = 0; v < NV; v++) begin
         for (int i = 0; i < vec[v].n; i++) begin
            if (i > 0) idle(vec[v].gap);
            cur = vec[v].b[55-8*i -: 8];
            send_byte(cur);
         end
         serve_pkt($sformatf("vec%0d", v), vec[v].exp_req, 5, 0);
         check_results($sformatf("vec%0d", v), vec[v].exp_req ? 1 : 0, vec[v].addr, vec[v].wdata, 1, vec[v].st);
         check($sformatf("vec%0d drop_cnt", v), bus.drop_cnt, 0);
      end

      // Byte timeout: BT cycles of silence, then one RESPOND cycle before the strobe
      send_byte(8'hAA);
      idle(2);
      send_byte(8'h10);
      n = 0;
      found = 0;
      while (!found && n < BUDGET) begin
         tick();
         n++;
         if (bus.tx_start) found = 1;
      end
      check("byte_to latency", n, BT + 1);
      check("byte_to tx_data", bus.tx_data, 8'hE0);
      check("byte_to busy", bus.busy, 0);
      tick();
      check_results("byte_to", 0, 8'h00, 16'h0000, 1, 8'hE0);

      // ACK timeout with three bytes dropped while waiting
      send_pkt(8'h20, 8'h00, 8'h07, 8'h27, 1);
      tick();
      hi = 0;
      while (bus.reg_req && hi < BUDGET) begin
         hi++;
         if (hi <= 3) send_byte(8'hAA);
         else tick();
      end
      check("ack_to req_cycles", hi, AT);
      wait_idle("ack_to");
      check_results("ack_to", 1, 8'h20, 16'h0007, 1, 8'hEF);
      check("ack_to drop_cnt", bus.drop_cnt, 3);

      // ACK on the same cycle as ACK expiry wins
      send_pkt(8'h30, 8'h12, 8'h34, 8'h16, 0);
      tick();
      idle(AT - 1);
      check("ack_race req_before", bus.reg_req, 1);
      bus.reg_ack = 1'b1;
      tick();
      bus.reg_ack = 1'b0;
      check("ack_race req_drop", bus.reg_req, 0);
      wait_idle("ack_race");
      check_results("ack_race", 1, 8'h30, 16'h1234, 1, 8'h55);

      // Random packets against the reference model
      exp_drop = 3;
      for (int k = 0; k < 25; k++) begin
         ng = int'($urandom_range(0, 3));
         for (int j = 0; j < ng; j++) begin
            g = 8'($urandom);
            if (g == 8'hAA) g = 8'h00;
            idle(int'($urandom_range(0, 3)));
            send_byte(g);
         end
         a  = 8'($urandom);
         dh = 8'($urandom);
         dl = 8'($urandom);
         chk = a ^ dh ^ dl;
         if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
         good = (ref_status(a, dh, dl, chk) == 8'h55);
         send_pkt(a, dh, dl, chk, int'($urandom_range(0, 6)));
         ad = int'($urandom_range(1, 8));
         ne = int'($urandom_range(0, (ad < 2) ? ad : 2));
         serve_pkt($sformatf("rnd%0d", k), good, ad, ne);
         if (good) exp_drop = (exp_drop + ne > 255) ? 255 : exp_drop + ne;
         check_results($sformatf("rnd%0d", k), good ? 1 : 0, a, {dh, dl}, 1, ref_status(a, dh, dl, chk));
         check($sformatf("rnd%0d drop_cnt", k), bus.drop_cnt, exp_drop);
      end

      // TX_BUSY stall in RESPOND, flooding RX to saturate DROP_CNT
      bus.tx_busy = 1'b1;
      send_pkt(8'h40, 8'h00, 8'h01, 8'h41, 1);
      tick();
      check("txbusy req_rise", bus.reg_req, 1);
      bus.reg_ack = 1'b1;
      tick();
      bus.reg_ack = 1'b0;
      seen = 0;
      for (int i = 0; i < 300; i++) begin
         bus.rx_data  = 8'($urandom);
         bus.rx_ready = 1'b1;
         tick();
         if (bus.tx_start) seen++;
      end
      bus.rx_ready = 1'b0;
      check("txbusy no_start", seen, 0);
      check("txbusy busy_held", bus.busy, 1);
      check("drop_cnt saturate", bus.drop_cnt, 255);
      bus.tx_busy = 1'b0;
      tick();
      check("txbusy start", bus.tx_start, 1);
      check("txbusy tx_data", bus.tx_data, 8'h55);
      tick();
      check("txbusy start_end", bus.tx_start, 0);
      check("txbusy idle", bus.busy, 0);
      check_results("txbusy", 1, 8'h40, 16'h0001, 1, 8'h55);

      // Asynchronous reset during WAIT_ACK abandons the request silently
      send_pkt(8'h50, 8'hAB, 8'hCD, 8'h36, 1);
      tick();
      idle(4);
      check("rst_mid req_before", bus.reg_req, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid reg_req", bus.reg_req, 0);
      check("rst_mid busy", bus.busy, 0);
      check("rst_mid drop_cnt", bus.drop_cnt, 0);
      check("rst_mid tx_data", bus.tx_data, 0);
      check("rst_mid reg_addr", bus.reg_addr, 0);
      idle(2);
      rst_n = 1'b1;
      idle(20);
      check_results("rst_mid", 1, 8'h50, 16'hABCD, 0, 8'h00);
      check("rst_mid drop_after", bus.drop_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
